// File: rtl/ram_unit_if.sv
// RAM port and loader stream between processor/loader and ram_unit.
// The master side drives address, write data and loader bytes.
interface ram_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_we;
  logic [DATA_W-1:0] ram_out;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic              cpu_hold;

  modport master (
    output ram_addr,
    output ram_data,
    output ram_we,
    output load_valid,
    output load_data,
    output load_last,
    input  ram_out,
    input  load_ready,
    input  load_done,
    input  cpu_hold
  );

  modport slave (
    input  ram_addr,
    input  ram_data,
    input  ram_we,
    input  load_valid,
    input  load_data,
    input  load_last,
    output ram_out,
    output load_ready,
    output load_done,
    output cpu_hold
  );
endinterface

// File: rtl/ram_unit.sv
// Byte-wide program RAM: clears itself, loads a program from a
// valid/ready stream, then serves the processor RAM port.
module ram_unit #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  ram_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    CLEAR,
    LOAD,
    RUN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              ready_q;
  logic              done_q;
  logic              hold_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign accept = ready_q && bus.load_valid;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ptr;
    wr_data = '0;
    unique case (1'b1)
      (state == CLEAR): begin
        wr_en = 1'b1;
      end
      (state == LOAD): begin
        wr_en   = accept;
        wr_data = bus.load_data;
      end
      (state == RUN): begin
        wr_en   = bus.ram_we;
        wr_addr = bus.ram_addr;
        wr_data = bus.ram_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      ptr     <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      unique case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST_ADDR) begin
            state   <= LOAD;
            ptr     <= '0;
            ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            ptr <= ptr + 1'b1;
            if (bus.load_last ||
                ptr == LAST_ADDR) begin
              state   <= RUN;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end
          end
        end
        RUN: ;
        default: begin
          state   <= CLEAR;
          ptr     <= '0;
          ready_q <= 1'b0;
          done_q  <= 1'b0;
          hold_q  <= 1'b1;
        end
      endcase
    end
  end

  // Array has no reset; rst only blocks writes while asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign bus.ram_out    = done_q ? mem[bus.ram_addr] : '0;
  assign bus.load_ready = ready_q;
  assign bus.load_done  = done_q;
  assign bus.cpu_hold   = hold_q;

endmodule
